// File: rtl/tcp_conn_ctrl.sv
// ============================================================================
// Module      : tcp_conn_ctrl
// Description : Passive-open TCP connection controller with a single-entry
//               response request slot. Optional SYN-ACK retry timer is built
//               only when macro TCP_SYNACK_RETRY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_conn_ctrl #(
  parameter logic [15:0] LOCAL_PORT    = 16'd80,
  parameter logic [31:0] ISN           = 32'h0000_1000,
  parameter logic [31:0] RETRY_TIMEOUT = 32'd125_000_000,
  parameter logic [1:0]  MAX_RETRY     = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_done_i,
  input  logic        crc_ok_i,
  input  logic [15:0] src_port_i,
  input  logic [15:0] dst_port_i,
  input  logic [31:0] seq_num_i,
  input  logic [31:0] ack_num_i,
  input  logic [5:0]  flags_i,
  input  logic [15:0] payload_len_i,
  output logic        tx_req_o,
  input  logic        tx_ack_i,
  output logic [5:0]  tx_flags_o,
  output logic [31:0] tx_seq_o,
  output logic [31:0] tx_ack_num_o,
  output logic [15:0] tx_dst_port_o,
  output logic [1:0]  state_o,
  output logic        conn_open_o
);

  localparam logic [1:0] S_LISTEN      = 2'd0;
  localparam logic [1:0] S_SYN_RCVD    = 2'd1;
  localparam logic [1:0] S_ESTABLISHED = 2'd2;
  localparam logic [1:0] S_LAST_ACK    = 2'd3;

  localparam int F_FIN = 0;
  localparam int F_SYN = 1;
  localparam int F_RST = 2;
  localparam int F_ACK = 4;

  localparam logic [5:0] FL_ACK     = 6'h10;
  localparam logic [5:0] FL_SYN_ACK = 6'h12;
  localparam logic [5:0] FL_FIN_ACK = 6'h11;

  logic [1:0]  state, state_d;
  logic [31:0] rcv_nxt, rcv_d;
  logic [31:0] snd_nxt, snd_d;
  logic [15:0] remote_port, rport_d;

  logic        q_en, cancel;
  logic [5:0]  q_flags;
  logic [31:0] q_seq, q_ack;

  logic        seg_valid, in_order, has_data;
  logic [31:0] len32;

  assign seg_valid = pkt_done_i && crc_ok_i && (dst_port_i == LOCAL_PORT) &&
                     ((state == S_LISTEN) || (src_port_i == remote_port));
  assign in_order  = (seq_num_i == rcv_nxt);
  assign len32     = {16'd0, payload_len_i};
  assign has_data  = (payload_len_i != 16'd0);

`ifdef TCP_SYNACK_RETRY_EN
  logic [31:0] retry_timer;
  logic [1:0]  retry_cnt;
  logic        retry_fire;

  assign retry_fire = (retry_timer == RETRY_TIMEOUT - 32'd1);
`endif

  always_comb begin
    state_d = state;
    rcv_d   = rcv_nxt;
    snd_d   = snd_nxt;
    rport_d = remote_port;
    q_en    = 1'b0;
    cancel  = 1'b0;
    q_flags = FL_ACK;
    q_seq   = snd_nxt;
    q_ack   = rcv_nxt;

    if (seg_valid) begin
      if ((state != S_LISTEN) && flags_i[F_RST]) begin
        state_d = S_LISTEN;
        rport_d = 16'd0;
        cancel  = 1'b1;
      end else begin
        case (state)
          S_LISTEN: begin
            if (flags_i[F_SYN] && !flags_i[F_ACK] && !flags_i[F_RST]) begin
              rport_d = src_port_i;
              rcv_d   = seq_num_i + 32'd1;
              snd_d   = ISN;
              q_en    = 1'b1;
              q_flags = FL_SYN_ACK;
              q_seq   = ISN;
              q_ack   = seq_num_i + 32'd1;
              state_d = S_SYN_RCVD;
            end
          end
          S_SYN_RCVD: begin
            if (flags_i[F_ACK] && (ack_num_i == ISN + 32'd1)) begin
              snd_d   = ISN + 32'd1;
              state_d = S_ESTABLISHED;
            end
          end
          S_ESTABLISHED: begin
            // FIN consumes one sequence number on top of any payload
            if (in_order && flags_i[F_FIN]) begin
              rcv_d   = rcv_nxt + len32 + 32'd1;
              q_en    = 1'b1;
              q_flags = FL_FIN_ACK;
              q_ack   = rcv_nxt + len32 + 32'd1;
              state_d = S_LAST_ACK;
            end else if (in_order && has_data) begin
              rcv_d   = rcv_nxt + len32;
              q_en    = 1'b1;
              q_ack   = rcv_nxt + len32;
            end else if (!in_order && has_data) begin
              q_en    = 1'b1;
            end
          end
          default: begin
            if (flags_i[F_ACK] && (ack_num_i == snd_nxt + 32'd1)) begin
              state_d = S_LISTEN;
              rport_d = 16'd0;
            end
          end
        endcase
      end
    end

`ifdef TCP_SYNACK_RETRY_EN
    // A timeout only acts when no received segment moved us out of SYN_RCVD
    if ((state == S_SYN_RCVD) && (state_d == S_SYN_RCVD) && retry_fire) begin
      if (retry_cnt == MAX_RETRY) begin
        state_d = S_LISTEN;
        rport_d = 16'd0;
        cancel  = 1'b1;
      end else begin
        q_en    = 1'b1;
        q_flags = FL_SYN_ACK;
        q_seq   = ISN;
        q_ack   = rcv_nxt;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LISTEN;
      rcv_nxt     <= 32'd0;
      snd_nxt     <= 32'd0;
      remote_port <= 16'd0;
    end else begin
      state       <= state_d;
      rcv_nxt     <= rcv_d;
      snd_nxt     <= snd_d;
      remote_port <= rport_d;
    end
  end

  // Single-entry slot: newest response wins, even over a same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_req_o      <= 1'b0;
      tx_flags_o    <= 6'd0;
      tx_seq_o      <= 32'd0;
      tx_ack_num_o  <= 32'd0;
      tx_dst_port_o <= 16'd0;
    end else if (cancel) begin
      tx_req_o      <= 1'b0;
    end else if (q_en) begin
      tx_req_o      <= 1'b1;
      tx_flags_o    <= q_flags;
      tx_seq_o      <= q_seq;
      tx_ack_num_o  <= q_ack;
      tx_dst_port_o <= rport_d;
    end else if (tx_req_o && tx_ack_i) begin
      tx_req_o      <= 1'b0;
    end
  end

`ifdef TCP_SYNACK_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_timer <= 32'd0;
      retry_cnt   <= 2'd0;
    end else if ((state != S_SYN_RCVD) || (state_d != S_SYN_RCVD)) begin
      retry_timer <= 32'd0;
      retry_cnt   <= 2'd0;
    end else if (retry_fire) begin
      retry_timer <= 32'd0;
      retry_cnt   <= retry_cnt + 2'd1;
    end else begin
      retry_timer <= retry_timer + 32'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{flags_i[5], flags_i[3]};
`else
  logic unused_ok;
  assign unused_ok = ^{flags_i[5], flags_i[3], RETRY_TIMEOUT, MAX_RETRY};
`endif

  assign state_o     = state;
  assign conn_open_o = (state == S_ESTABLISHED);

endmodule

`default_nettype wire

// File: tb/tb_tcp_conn_ctrl.sv
// ============================================================================
// Module      : tb_tcp_conn_ctrl
// Description : Directed and randomized bench for tcp_conn_ctrl against a
//               connection-level reference model (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcp_conn_ctrl;

  localparam logic [31:0] ISN = 32'h0000_1000;
  localparam int LISTEN = 0, SYN_RCVD = 1, ESTAB = 2, LAST_ACK = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_done_i, crc_ok_i, tx_ack_i;
  logic [15:0] src_port_i, dst_port_i, payload_len_i;
  logic [31:0] seq_num_i, ack_num_i;
  logic [5:0]  flags_i;
  logic        tx_req_o, conn_open_o;
  logic [5:0]  tx_flags_o;
  logic [31:0] tx_seq_o, tx_ack_num_o;
  logic [15:0] tx_dst_port_o;
  logic [1:0]  state_o;

  tcp_conn_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_done_i(pkt_done_i), .crc_ok_i(crc_ok_i),
    .src_port_i(src_port_i), .dst_port_i(dst_port_i),
    .seq_num_i(seq_num_i), .ack_num_i(ack_num_i),
    .flags_i(flags_i), .payload_len_i(payload_len_i),
    .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i),
    .tx_flags_o(tx_flags_o), .tx_seq_o(tx_seq_o),
    .tx_ack_num_o(tx_ack_num_o), .tx_dst_port_o(tx_dst_port_o),
    .state_o(state_o), .conn_open_o(conn_open_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: connection record plus one pending response
  int          m_state;
  logic [31:0] m_rcv, m_snd;
  logic [15:0] m_rport;
  bit          m_req;
  logic [5:0]  m_flags;
  logic [31:0] m_seq, m_ack;
  logic [15:0] m_dport;

  task automatic model_reset();
    m_state = LISTEN; m_rcv = 0; m_snd = 0; m_rport = 0; m_req = 0;
    m_flags = 0; m_seq = 0; m_ack = 0; m_dport = 0;
  endtask

  task automatic respond(input logic [5:0] fl);
    m_req = 1; m_flags = fl; m_seq = m_snd; m_ack = m_rcv; m_dport = m_rport;
  endtask

  task automatic model_step();
    bit valid, responded, reset_conn;
    valid = pkt_done_i && crc_ok_i && dst_port_i == 16'd80 &&
            (m_state == LISTEN || src_port_i == m_rport);
    responded = 0; reset_conn = 0;
    if (valid && m_state != LISTEN && flags_i[2]) begin
      m_state = LISTEN; m_rport = 0; reset_conn = 1;
    end else if (valid) begin
      if (m_state == LISTEN && flags_i[1] && !flags_i[4] && !flags_i[2]) begin
        m_rport = src_port_i; m_rcv = seq_num_i + 1; m_snd = ISN;
        respond(6'h12); responded = 1; m_state = SYN_RCVD;
      end else if (m_state == SYN_RCVD && flags_i[4] && ack_num_i == ISN + 1) begin
        m_snd = ISN + 1; m_state = ESTAB;
      end else if (m_state == ESTAB) begin
        if (seq_num_i == m_rcv && flags_i[0]) begin
          m_rcv = m_rcv + payload_len_i + 1;
          respond(6'h11); responded = 1; m_state = LAST_ACK;
        end else if (payload_len_i > 0) begin
          if (seq_num_i == m_rcv) m_rcv = m_rcv + payload_len_i;
          respond(6'h10); responded = 1;
        end
      end else if (m_state == LAST_ACK && flags_i[4] && ack_num_i == m_snd + 1) begin
        m_state = LISTEN; m_rport = 0;
      end
    end
    if (reset_conn) m_req = 0;
    else if (!responded && m_req && tx_ack_i) m_req = 0;
  endtask

  task automatic model_check();
    chk("req", tx_req_o, m_req);
    chk("state", state_o, m_state);
    chk("open", conn_open_o, m_state == ESTAB);
    if (m_req) begin
      chk("flags", tx_flags_o, m_flags);
      chk("seq", tx_seq_o, m_seq);
      chk("acknum", tx_ack_num_o, m_ack);
      chk("dport", tx_dst_port_o, m_dport);
    end
  endtask

  task automatic drive(input logic pd, input logic crc, input logic [15:0] src,
                       input logic [15:0] dst, input logic [31:0] sq, input logic [31:0] an,
                       input logic [5:0] fl, input logic [15:0] len, input logic ta);
    @(negedge clk);
    model_check();
    pkt_done_i = pd; crc_ok_i = crc; src_port_i = src; dst_port_i = dst;
    seq_num_i = sq; ack_num_i = an; flags_i = fl; payload_len_i = len; tx_ack_i = ta;
    model_step();
  endtask

  task automatic idle(input logic ta);
    drive(1'b0, 1'b1, 16'd0, 16'd80, 32'd0, 32'd0, 6'd0, 16'd0, ta);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pkt_done_i = 0; crc_ok_i = 0; src_port_i = 0; dst_port_i = 0;
    seq_num_i = 0; ack_num_i = 0; flags_i = 0; payload_len_i = 0; tx_ack_i = 0;
    model_reset();
    #1;
    chk("rst_req", tx_req_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_open", conn_open_o, 0);
    chk("rst_flags", tx_flags_o, 0);
    chk("rst_seq", tx_seq_o, 0);
    chk("rst_ack", tx_ack_num_o, 0);
    chk("rst_dport", tx_dst_port_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0]  fl;
    logic [31:0] sq, an;
    logic [15:0] src, dst, len;
    rst_n = 1'b1;
    do_reset();

    // Handshake and first data segment
    drive(1, 1, 16'd1234, 16'd80, 32'h100, 32'h0, 6'h02, 16'd0, 0);
    post_edge();
    chk("syn_req", tx_req_o, 1);
    chk("syn_flags", tx_flags_o, 6'h12);
    chk("syn_seq", tx_seq_o, 32'h1000);
    chk("syn_ack", tx_ack_num_o, 32'h101);
    chk("syn_state", state_o, 1);
    drive(1, 1, 16'd1234, 16'd80, 32'h101, 32'h1001, 6'h10, 16'd0, 0);
    post_edge();
    chk("est_state", state_o, 2);
    drive(1, 1, 16'd1234, 16'd80, 32'h101, 32'h1001, 6'h18, 16'd10, 0);
    post_edge();
    chk("data_flags", tx_flags_o, 6'h10);
    chk("data_ack", tx_ack_num_o, 32'h10B);
    chk("data_seq", tx_seq_o, 32'h1001);

    // Stall, overwrite during stall, then one accept
    repeat (5) idle(0);
    chk("stall_req", tx_req_o, 1);
    chk("stall_ack", tx_ack_num_o, 32'h10B);
    drive(1, 1, 16'd1234, 16'd80, 32'h10B, 32'h1001, 6'h18, 16'd5, 0);
    post_edge();
    chk("ovw_ack", tx_ack_num_o, 32'h110);
    idle(1);
    post_edge();
    chk("accept_req", tx_req_o, 0);

    // Close
    drive(1, 1, 16'd1234, 16'd80, 32'h110, 32'h1001, 6'h11, 16'd0, 0);
    post_edge();
    chk("fin_flags", tx_flags_o, 6'h11);
    chk("fin_ack", tx_ack_num_o, 32'h111);
    chk("fin_state", state_o, 3);
    drive(1, 1, 16'd1234, 16'd80, 32'h111, 32'h1002, 6'h10, 16'd0, 0);
    post_edge();
    chk("close_state", state_o, 0);

    // Sequence wrap and duplicate ACK
    drive(1, 1, 16'd2222, 16'd80, 32'hFFFF_FFFD, 32'h0, 6'h02, 16'd0, 1);
    drive(1, 1, 16'd2222, 16'd80, 32'hFFFF_FFFE, 32'h1001, 6'h10, 16'd0, 1);
    drive(1, 1, 16'd2222, 16'd80, 32'hFFFF_FFFE, 32'h1001, 6'h18, 16'd4, 0);
    post_edge();
    chk("wrap_ack", tx_ack_num_o, 32'h2);
    drive(1, 1, 16'd2222, 16'd80, 32'h5, 32'h1001, 6'h18, 16'd3, 0);
    post_edge();
    chk("dup_ack", tx_ack_num_o, 32'h2);
    chk("dup_flags", tx_flags_o, 6'h10);

    // RST handling
    drive(1, 1, 16'd2222, 16'd80, 32'h2, 32'h0, 6'h04, 16'd0, 0);
    drive(1, 1, 16'd3333, 16'd80, 32'h500, 32'h0, 6'h02, 16'd0, 0);
    drive(1, 0, 16'd3333, 16'd80, 32'h501, 32'h0, 6'h04, 16'd0, 0);
    post_edge();
    chk("rst_badcrc_state", state_o, 1);
    drive(1, 1, 16'd3333, 16'd80, 32'h501, 32'h0, 6'h04, 16'd0, 0);
    post_edge();
    chk("rst_good_state", state_o, 0);
    chk("rst_good_req", tx_req_o, 0);

    // Reset mid-request drops it
    drive(1, 1, 16'd4444, 16'd80, 32'h700, 32'h0, 6'h02, 16'd0, 0);
    do_reset();
    repeat (3) idle(0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      src = (m_state == LISTEN) ? 16'(1000 + $urandom_range(0, 3))
          : (($urandom_range(0, 7) != 0) ? m_rport : m_rport + 16'd1);
      dst = ($urandom_range(0, 9) != 0) ? 16'd80 : 16'd81;
      len = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      sq = $urandom;
      an = $urandom;
      fl = 6'($urandom);
      case (m_state)
        LISTEN: begin
          if ($urandom_range(0, 9) < 7) fl = 6'h02;
          if ($urandom_range(0, 3) == 0) sq = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        end
        SYN_RCVD: begin
          if ($urandom_range(0, 19) < 14) fl = 6'h10;
          else if ($urandom_range(0, 9) == 0) fl = 6'h04;
          else fl = fl & 6'h3B;
          if ($urandom_range(0, 4) != 0) an = ISN + 1;
        end
        ESTAB: begin
          if ($urandom_range(0, 19) < 12) fl = 6'h18;
          else if ($urandom_range(0, 19) < 6) fl = 6'h11;
          else if ($urandom_range(0, 19) == 0) fl = 6'h04;
          else fl = fl & 6'h3B;
          sq = ($urandom_range(0, 4) != 0) ? m_rcv : m_rcv + $urandom_range(1, 50);
        end
        default: begin
          if ($urandom_range(0, 9) < 7) fl = 6'h10;
          else fl = fl & 6'h3B;
          if ($urandom_range(0, 4) != 0) an = m_snd + 1;
        end
      endcase
      drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 7) != 0),
            src, dst, sq, an, fl, len, 1'($urandom_range(0, 1)));
    end
    idle(0);
    @(negedge clk);
    model_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
